// File: rtl/aes_pkg.sv
// Shared AES definitions: byte counts, scheduler/arbiter enums and the forward S-box table.
package aes_pkg;

    localparam int STATE_BYTES = 16;
    localparam int WORD_BYTES  = 4;

    typedef enum logic [2:0] {
        IDLE,
        RUN_ST,
        RUN_KEY,
        DONE_ST,
        DONE_KEY
    } sbox_sched_state_t;

    typedef enum logic {
        GNT_ST,
        GNT_KEY
    } grant_t;

    localparam logic [7:0] SBOX_LUT [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_LUT[b];
    endfunction

endpackage

// File: rtl/sbox_bank.sv
// Purely combinational bank of NUM_SBOX forward S-box lookups; lane i maps din byte i to dout byte i.
module sbox_bank
    import aes_pkg::*;
#(
    parameter int NUM_SBOX = 4
) (
    input  logic [NUM_SBOX*8-1:0] din,
    output logic [NUM_SBOX*8-1:0] dout
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SBOX; gi++) begin : g_lane
            assign dout[gi*8 +: 8] = sbox(din[gi*8 +: 8]);
        end
    endgenerate

endmodule

// File: rtl/sbox_scheduler.sv
// Shares NUM_SBOX S-box lanes between SubBytes (16-byte state) and SubWord (4-byte key word) requesters.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise key requests always win a tie.
module sbox_scheduler
    import aes_pkg::*;
#(
    parameter int NUM_SBOX = 4
) (
    input  logic         CLK,
    input  logic         rst_n,
    input  logic         st_in_valid,
    output logic         st_in_ready,
    input  logic [127:0] st_in_data,
    output logic         st_out_valid,
    input  logic         st_out_ready,
    output logic [127:0] st_out_data,
    input  logic         key_in_valid,
    output logic         key_in_ready,
    input  logic [31:0]  key_in_data,
    output logic         key_out_valid,
    input  logic         key_out_ready,
    output logic [31:0]  key_out_data,
    output logic         busy
);

    localparam int N_ST   = STATE_BYTES / NUM_SBOX;
    localparam int N_KEY  = (NUM_SBOX >= WORD_BYTES) ? 1 : WORD_BYTES / NUM_SBOX;
    localparam int CW     = (N_ST > 1) ? $clog2(N_ST) : 1;
    localparam int N_SLOT = 1 << CW;
    localparam int W      = NUM_SBOX * 8;
    localparam logic [CW-1:0] LAST_ST  = CW'(N_ST - 1);
    localparam logic [CW-1:0] LAST_KEY = CW'(N_KEY - 1);

    if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 || NUM_SBOX == 8 || NUM_SBOX == 16)) begin : g_bad_num_sbox
        $error("sbox_scheduler: NUM_SBOX must be 1, 2, 4, 8 or 16");
    end

    sbox_sched_state_t state_reg;
    logic [CW-1:0]     chunk_reg;
    logic [127:0]      in_flat;
    logic [W-1:0]      chunk_data [N_SLOT];
    logic [W-1:0]      bank_in;
    logic [W-1:0]      bank_out;
    logic              idle;
    logic              key_acc;
    logic              st_acc;

    // Readies are gated by rst_n so every output reads 0 while reset is held.
    assign idle = rst_n && (state_reg == IDLE);

`ifdef ARB_RR_EN
    grant_t last_grant_reg;

    assign key_in_ready = idle && (!st_in_valid || last_grant_reg == GNT_ST);
    assign st_in_ready  = idle && (!key_in_valid || last_grant_reg == GNT_KEY);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= GNT_ST;
        end else if (key_acc) begin
            last_grant_reg <= GNT_KEY;
        end else if (st_acc) begin
            last_grant_reg <= GNT_ST;
        end
    end
`else
    assign key_in_ready = idle;
    assign st_in_ready  = idle && !key_in_valid;
`endif

    assign key_acc = key_in_valid && key_in_ready;
    assign st_acc  = st_in_valid && st_in_ready;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            chunk_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    chunk_reg <= '0;
                    if (key_acc) begin
                        state_reg <= RUN_KEY;
                    end else if (st_acc) begin
                        state_reg <= RUN_ST;
                    end
                end
                RUN_ST: begin
                    if (chunk_reg == LAST_ST) begin
                        state_reg <= DONE_ST;
                    end else begin
                        chunk_reg <= chunk_reg + 1'b1;
                    end
                end
                RUN_KEY: begin
                    if (chunk_reg == LAST_KEY) begin
                        state_reg <= DONE_KEY;
                    end else begin
                        chunk_reg <= chunk_reg + 1'b1;
                    end
                end
                DONE_ST: begin
                    if (st_out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                DONE_KEY: begin
                    if (key_out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy          = (state_reg != IDLE);
    assign st_out_valid  = (state_reg == DONE_ST);
    assign key_out_valid = (state_reg == DONE_KEY);

    genvar gi;
    generate
        // Per-byte capture and result registers; a key word lands zero-extended in bytes 0..3.
        for (gi = 0; gi < STATE_BYTES; gi++) begin : g_byte
            localparam logic [CW-1:0] CHUNK = CW'(gi / NUM_SBOX);
            localparam int            LANE  = gi % NUM_SBOX;

            logic [7:0] in_byte_reg;
            logic [7:0] st_res_reg;
            logic [7:0] key_byte;

            always_ff @(posedge CLK or negedge rst_n) begin
                if (!rst_n) begin
                    in_byte_reg <= '0;
                end else if (key_acc) begin
                    in_byte_reg <= key_byte;
                end else if (st_acc) begin
                    in_byte_reg <= st_in_data[gi*8 +: 8];
                end
            end

            always_ff @(posedge CLK or negedge rst_n) begin
                if (!rst_n) begin
                    st_res_reg <= '0;
                end else if (state_reg == RUN_ST && chunk_reg == CHUNK) begin
                    st_res_reg <= bank_out[LANE*8 +: 8];
                end
            end

            assign in_flat[gi*8 +: 8]     = in_byte_reg;
            assign st_out_data[gi*8 +: 8] = st_res_reg;

            if (gi < WORD_BYTES) begin : g_word
                logic [7:0] key_res_reg;

                always_ff @(posedge CLK or negedge rst_n) begin
                    if (!rst_n) begin
                        key_res_reg <= '0;
                    end else if (state_reg == RUN_KEY && chunk_reg == CHUNK) begin
                        key_res_reg <= bank_out[LANE*8 +: 8];
                    end
                end

                assign key_byte                = key_in_data[gi*8 +: 8];
                assign key_out_data[gi*8 +: 8] = key_res_reg;
            end else begin : g_pad
                assign key_byte = 8'h00;
            end
        end

        // Slots beyond the last real chunk exist only so the counter can index a power-of-two table.
        for (gi = 0; gi < N_SLOT; gi++) begin : g_slot
            if (gi < N_ST) begin : g_real
                assign chunk_data[gi] = in_flat[gi*W +: W];
            end else begin : g_unused
                assign chunk_data[gi] = '0;
            end
        end
    endgenerate

    assign bank_in = chunk_data[chunk_reg];

    sbox_bank #(
        .NUM_SBOX(NUM_SBOX)
    ) u_bank (
        .din (bank_in),
        .dout(bank_out)
    );

endmodule

// File: tb/tb_sbox_scheduler.sv
// Directed bench for sbox_scheduler: NUM_SBOX = 4, 1 and 16 instances share the same stimulus.
module tb_sbox_scheduler;

    logic         CLK = 1'b0;
    logic         rst_n = 1'b0;
    logic         st_in_valid = 1'b0;
    logic         st_out_ready = 1'b1;
    logic         key_in_valid = 1'b0;
    logic         key_out_ready = 1'b1;
    logic [127:0] st_in_data = '0;
    logic [31:0]  key_in_data = '0;

    logic [2:0]   st_in_ready_v, st_out_valid_v, key_in_ready_v, key_out_valid_v, busy_v;
    logic [127:0] st_out_data_v [3];
    logic [31:0]  key_out_data_v [3];

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit           is_key;
        logic [127:0] din;
        logic [127:0] exp;
        int           lat4;
        int           lat1;
        int           lat16;
    } vec_t;

    vec_t vecs [6];

    always #5 CLK = ~CLK;

    sbox_scheduler #(.NUM_SBOX(4)) dut4 (
        .CLK(CLK), .rst_n(rst_n),
        .st_in_valid(st_in_valid), .st_in_ready(st_in_ready_v[0]), .st_in_data(st_in_data),
        .st_out_valid(st_out_valid_v[0]), .st_out_ready(st_out_ready), .st_out_data(st_out_data_v[0]),
        .key_in_valid(key_in_valid), .key_in_ready(key_in_ready_v[0]), .key_in_data(key_in_data),
        .key_out_valid(key_out_valid_v[0]), .key_out_ready(key_out_ready), .key_out_data(key_out_data_v[0]),
        .busy(busy_v[0])
    );

    sbox_scheduler #(.NUM_SBOX(1)) dut1 (
        .CLK(CLK), .rst_n(rst_n),
        .st_in_valid(st_in_valid), .st_in_ready(st_in_ready_v[1]), .st_in_data(st_in_data),
        .st_out_valid(st_out_valid_v[1]), .st_out_ready(st_out_ready), .st_out_data(st_out_data_v[1]),
        .key_in_valid(key_in_valid), .key_in_ready(key_in_ready_v[1]), .key_in_data(key_in_data),
        .key_out_valid(key_out_valid_v[1]), .key_out_ready(key_out_ready), .key_out_data(key_out_data_v[1]),
        .busy(busy_v[1])
    );

    sbox_scheduler #(.NUM_SBOX(16)) dut16 (
        .CLK(CLK), .rst_n(rst_n),
        .st_in_valid(st_in_valid), .st_in_ready(st_in_ready_v[2]), .st_in_data(st_in_data),
        .st_out_valid(st_out_valid_v[2]), .st_out_ready(st_out_ready), .st_out_data(st_out_data_v[2]),
        .key_in_valid(key_in_valid), .key_in_ready(key_in_ready_v[2]), .key_in_data(key_in_data),
        .key_out_valid(key_out_valid_v[2]), .key_out_ready(key_out_ready), .key_out_data(key_out_data_v[2]),
        .busy(busy_v[2])
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic wait_all_idle();
        int n;
        n = 0;
        st_out_ready  = 1'b1;
        key_out_ready = 1'b1;
        while (busy_v != 3'b000 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) check("idle_timeout", 128'(busy_v), 128'(0));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int           lat [3];
        int           exp_lat [3];
        bit           seen [3];
        logic [127:0] got [3];
        exp_lat = '{v.lat4, v.lat1, v.lat16};
        for (int d = 0; d < 3; d++) begin
            lat[d]  = -1;
            seen[d] = 1'b0;
            got[d]  = '0;
        end
        wait_all_idle();
        @(negedge CLK);
        if (v.is_key) begin
            key_in_valid = 1'b1;
            key_in_data  = v.din[31:0];
        end else begin
            st_in_valid = 1'b1;
            st_in_data  = v.din;
        end
        #1;
        check($sformatf("vec%0d_in_ready", idx),
              128'(v.is_key ? key_in_ready_v[0] : st_in_ready_v[0]), 128'(1));
        @(posedge CLK);
        @(negedge CLK);
        key_in_valid = 1'b0;
        st_in_valid  = 1'b0;
        key_in_data  = 32'hdeadbeef;
        st_in_data   = {4{32'hdeadbeef}};
        for (int k = 0; k < 40; k++) begin
            for (int d = 0; d < 3; d++) begin
                if (!seen[d] && (v.is_key ? key_out_valid_v[d] : st_out_valid_v[d])) begin
                    seen[d] = 1'b1;
                    lat[d]  = k;
                    got[d]  = v.is_key ? {96'b0, key_out_data_v[d]} : st_out_data_v[d];
                end
            end
            if (seen[0] && seen[1] && seen[2]) break;
            @(negedge CLK);
        end
        for (int d = 0; d < 3; d++) begin
            check($sformatf("vec%0d_dut%0d_latency", idx, d), 128'(lat[d]), 128'(exp_lat[d]));
            check($sformatf("vec%0d_dut%0d_data", idx, d), got[d], v.exp);
        end
        $display("[TB] txn vec%0d %s in=%h out4=%h lat4=%0d lat1=%0d lat16=%0d",
                 idx, v.is_key ? "key" : "st", v.din, got[0], lat[0], lat[1], lat[2]);
    endtask

    task automatic tie_seq();
        bit exp_key [4];
        bit is_key;
        int n;
`ifdef ARB_RR_EN
        exp_key = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_key = '{1'b1, 1'b1, 1'b1, 1'b0};
`endif
        wait_all_idle();
        @(negedge CLK);
        key_in_data  = 32'h00000053;
        st_in_data   = '1;
        key_in_valid = 1'b1;
        st_in_valid  = 1'b1;
        for (int g = 0; g < 4; g++) begin
            if (g == 3) key_in_valid = 1'b0;
            #1;
            n = 0;
            while (!((key_in_valid && key_in_ready_v[0]) || (st_in_valid && st_in_ready_v[0])) && n < 40) begin
                @(negedge CLK);
                #1;
                n++;
            end
            is_key = key_in_valid && key_in_ready_v[0];
            check($sformatf("tie_grant%0d", g), 128'(is_key), 128'(exp_key[g]));
            @(posedge CLK);
            @(negedge CLK);
            #1;
            n = 0;
            while (!(key_out_valid_v[0] || st_out_valid_v[0]) && n < 40) begin
                @(negedge CLK);
                #1;
                n++;
            end
            check($sformatf("tie_key_valid%0d", g), 128'(key_out_valid_v[0]), 128'(exp_key[g]));
            check($sformatf("tie_st_valid%0d", g), 128'(st_out_valid_v[0]), 128'(!exp_key[g]));
            if (exp_key[g]) check($sformatf("tie_key_data%0d", g), 128'(key_out_data_v[0]), 128'h636363ed);
            else            check($sformatf("tie_st_data%0d", g), st_out_data_v[0], {16{8'h16}});
            $display("[TB] txn tie%0d granted=%s key_out=%h st_out=%h",
                     g, is_key ? "key" : "st", key_out_data_v[0], st_out_data_v[0]);
        end
        st_in_valid = 1'b0;
    endtask

    task automatic backpressure_seq();
        logic [127:0] exp_st;
        int n;
        exp_st = 128'h637c777bf26b6fc53001672bfed7ab76;
        wait_all_idle();
        @(negedge CLK);
        st_out_ready = 1'b0;
        st_in_valid  = 1'b1;
        st_in_data   = 128'h000102030405060708090a0b0c0d0e0f;
        @(posedge CLK);
        @(negedge CLK);
        st_in_valid = 1'b0;
        n = 0;
        while (!st_out_valid_v[0] && n < 40) begin
            @(negedge CLK);
            n++;
        end
        key_in_valid = 1'b1;
        key_in_data  = 32'hcf4f3c09;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("bp_st_valid%0d", c), 128'(st_out_valid_v[0]), 128'(1));
            check($sformatf("bp_st_data%0d", c), st_out_data_v[0], exp_st);
            check($sformatf("bp_key_ready%0d", c), 128'(key_in_ready_v[0]), 128'(0));
            check($sformatf("bp_st_ready%0d", c), 128'(st_in_ready_v[0]), 128'(0));
            check($sformatf("bp_key_valid%0d", c), 128'(key_out_valid_v[0]), 128'(0));
            @(negedge CLK);
        end
        st_out_ready = 1'b1;
        #1;
        check("bp_key_ready_at_handshake", 128'(key_in_ready_v[0]), 128'(0));
        @(posedge CLK);
        @(negedge CLK);
        #1;
        check("bp_st_valid_after", 128'(st_out_valid_v[0]), 128'(0));
        check("bp_busy_after", 128'(busy_v[0]), 128'(0));
        check("bp_key_ready_after", 128'(key_in_ready_v[0]), 128'(1));
        @(posedge CLK);
        @(negedge CLK);
        key_in_valid = 1'b0;
        #1;
        check("bp_key_busy", 128'(busy_v[0]), 128'(1));
        check("bp_key_not_yet", 128'(key_out_valid_v[0]), 128'(0));
        @(negedge CLK);
        #1;
        check("bp_key_valid", 128'(key_out_valid_v[0]), 128'(1));
        check("bp_key_data", 128'(key_out_data_v[0]), 128'h8a84eb01);
        $display("[TB] txn backpressure st=%h key=%h", st_out_data_v[0], key_out_data_v[0]);
    endtask

    task automatic reset_mid_seq();
        bit spurious;
        wait_all_idle();
        @(negedge CLK);
        st_in_valid = 1'b1;
        st_in_data  = 128'h000102030405060708090a0b0c0d0e0f;
        @(posedge CLK);
        @(negedge CLK);
        st_in_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 128'(busy_v[0]), 128'(0));
        check("rst_mid_st_valid", 128'(st_out_valid_v[0]), 128'(0));
        check("rst_mid_st_data", st_out_data_v[0], 128'(0));
        check("rst_mid_key_ready", 128'(key_in_ready_v[0]), 128'(0));
        check("rst_mid_st_ready", 128'(st_in_ready_v[0]), 128'(0));
        @(negedge CLK);
        @(negedge CLK);
        rst_n = 1'b1;
        spurious = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (st_out_valid_v[0]) spurious = 1'b1;
        end
        check("rst_mid_no_output", 128'(spurious), 128'(0));
        $display("[TB] txn reset_mid_run spurious_valid=%0d", spurious);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{is_key: 1'b0, din: 128'h000102030405060708090a0b0c0d0e0f,
                    exp: 128'h637c777bf26b6fc53001672bfed7ab76, lat4: 4, lat1: 16, lat16: 1};
        vecs[1] = '{is_key: 1'b1, din: 128'hcf4f3c09, exp: 128'h8a84eb01, lat4: 1, lat1: 4, lat16: 1};
        vecs[2] = '{is_key: 1'b1, din: 128'h00000053, exp: 128'h636363ed, lat4: 1, lat1: 4, lat16: 1};
        vecs[3] = '{is_key: 1'b0, din: {16{8'hff}}, exp: {16{8'h16}}, lat4: 4, lat1: 16, lat16: 1};
        vecs[4] = '{is_key: 1'b0, din: 128'h0, exp: {16{8'h63}}, lat4: 4, lat1: 16, lat16: 1};
        vecs[5] = '{is_key: 1'b1, din: 128'hffff0010, exp: 128'h161663ca, lat4: 1, lat1: 4, lat16: 1};

        // Requests held high during reset must not leak through any output.
        key_in_valid = 1'b1;
        st_in_valid  = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        check("rst_busy", 128'(busy_v[0]), 128'(0));
        check("rst_key_ready", 128'(key_in_ready_v[0]), 128'(0));
        check("rst_st_ready", 128'(st_in_ready_v[0]), 128'(0));
        check("rst_st_valid", 128'(st_out_valid_v[0]), 128'(0));
        check("rst_key_valid", 128'(key_out_valid_v[0]), 128'(0));
        check("rst_st_data", st_out_data_v[0], 128'(0));
        check("rst_key_data", 128'(key_out_data_v[0]), 128'(0));
        key_in_valid = 1'b0;
        st_in_valid  = 1'b0;
        @(negedge CLK);
        rst_n = 1'b1;
        @(negedge CLK);
        #1;
        check("idle_busy", 128'(busy_v[0]), 128'(0));
        check("idle_key_ready", 128'(key_in_ready_v[0]), 128'(1));
        check("idle_st_ready", 128'(st_in_ready_v[0]), 128'(1));
        key_in_valid = 1'b1;
        #1;
        check("idle_st_ready_key_pending", 128'(st_in_ready_v[0]), 128'(0));
        key_in_valid = 1'b0;
        $display("[TB] txn reset_and_idle");

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        tie_seq();
        backpressure_seq();
        reset_mid_seq();
        run_vec(vecs[3], 6);
        run_vec(vecs[1], 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
